fetch_next_pc: RTL
==================

// Module: fetch_next_pc
// PURPOSE
//  Fetch stage directly upstream of the PC register. Drives the PC register's next-PC input
//  (new_pc) from its current-PC output (current_pc).
//  Issues one-outstanding instruction-memory requests and buffers fetched {pc,instr} pairs
//  for decode. Applies branch redirects, including discarding any in-flight response.
// PARAMETERS
//  ADDR_W    16  PC / instruction-memory address width
//  DATA_W    16  instruction width
//  PC_STEP   1   PC increment per fetched instruction
//  DEPTH     2   fetch-buffer entries (power of 2, >=2)
//  RESET_PC  0   value held on new_pc during reset
// PORTS
//  clk             in   1       system clock; all state updates on posedge
//  rst_n           in   1       asynchronous active-low reset
//  current_pc      in   ADDR_W  PC register output
//  new_pc          out  ADDR_W  next PC; PC register samples it on negedge clk
//  branch_taken    in   1       redirect request from execute, single-cycle pulse
//  branch_target   in   ADDR_W  redirect address, valid with branch_taken
//  imem_req        out  1       memory request valid
//  imem_addr       out  ADDR_W  request address, stable while imem_req=1
//  imem_ready      in   1       request complete; imem_rdata valid this cycle
//  imem_rdata      in   DATA_W  fetched instruction
//  if_valid        out  1       buffer head valid to decode
//  if_instr        out  DATA_W  buffer head instruction
//  if_pc           out  ADDR_W  buffer head PC
//  dec_ready       in   1       decode accepts head when if_valid&dec_ready
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE, buffer count=0, req_addr=RESET_PC.
//   - imem_req=0, if_valid=0, new_pc=RESET_PC.
//   - Reset mid-request discards the request; no response is captured after release.
//  FSM states: IDLE, REQ, DROP. imem_req=1 in REQ and DROP; imem_addr=req_addr (registered).
//   - IDLE: if count<DEPTH and !branch_taken -> REQ, req_addr<=current_pc.
//   - REQ, imem_ready=1, no redirect:
//     - push {req_addr, imem_rdata}; new_pc=current_pc+PC_STEP.
//     - If post-push count<DEPTH -> stay REQ with req_addr<=current_pc+PC_STEP
//       (back-to-back fetch); else -> IDLE.
//   - REQ, branch_taken=1: no push.
//     - imem_ready=1 -> IDLE (response dropped); imem_ready=0 -> DROP.
//   - DROP: hold req/addr until imem_ready; then discard data -> IDLE.
//     - A further branch_taken here only updates new_pc.
//  new_pc (combinational, settles before negedge):
//   - branch_taken ? branch_target : (accepted push ? current_pc+PC_STEP : current_pc).
//   - Addition wraps modulo 2^ADDR_W; 16'hFFFF+1 -> 16'h0000.
//  Buffer: FIFO, DEPTH entries.
//   - Head drives if_*; pop on if_valid&dec_ready.
//   - Push and pop in the same cycle leaves count unchanged.
//   - Never pushes when full (guaranteed by the issue rule).
//   - branch_taken clears the buffer at the same posedge; push and pop that cycle are void.
//     if_valid=0 the following cycle.
//  Latency:
//   - IDLE -> imem_req 1 cycle.
//   - imem_ready -> if_valid at the next posedge (if the buffer was empty).
//  if_valid=0 implies if_instr/if_pc are don't-care.
// TESTING
//  1. Reset release, imem_ready tied 1, dec_ready=1:
//     imem_addr 0,1,2,3 on consecutive cycles; if_pc follows 1 cycle later; new_pc=current_pc+1.
//  2. dec_ready=0, ready=1:
//     2 pushes (PCs 0,1), then IDLE, imem_req=0, new_pc==current_pc. Raise dec_ready -> fetch resumes at 2.
//  3. branch_taken, target 16'h0040, while in REQ with ready=0 for 3 cycles:
//     DROP; stale data not pushed; buffer empty; next imem_addr=16'h0040.
//  4. branch_taken and imem_ready in the same cycle:
//     response dropped; new_pc=target; if_valid=0 next cycle.
//  5. current_pc=16'hFFFF, fetch accepted -> new_pc=16'h0000, if_pc=16'hFFFF.
//  6. rst_n low mid-REQ, asynchronously:
//     imem_req=0, if_valid=0, new_pc=0 immediately; restart at 0 after release.

Source files
------------

// File: rtl/fetch_next_pc.sv
// fetch_next_pc: fetch stage sitting directly upstream of the PC register.
// Issues one outstanding instruction-memory request at a time, buffers the
// fetched {pc, instr} pairs for decode and applies branch redirects, including
// discarding a response that is still in flight when the redirect arrives.
// The PC register samples new_pc on the falling edge, so by the next rising
// edge current_pc already holds the advanced PC. A back-to-back fetch
// therefore steps from the address just fetched rather than re-reading
// current_pc.
module fetch_next_pc #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 16,
  parameter int                PC_STEP  = 1,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] current_pc,
  output logic [ADDR_W-1:0] new_pc,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              dec_ready
);

  localparam int                PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                CNT_W = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(PC_STEP);
  localparam logic [CNT_W-1:0]  FULL  = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t            state;
  logic [ADDR_W-1:0] req_addr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_after;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [ADDR_W-1:0] buf_pc    [DEPTH];
  logic [DATA_W-1:0] buf_instr [DEPTH];
  logic              push;
  logic              pop;

  // Decide whether this cycle completes a usable fetch and/or hands an entry to decode
  always_comb begin
    push        = (state == REQ) && imem_ready && !branch_taken;
    pop         = (count != '0) && dec_ready && !branch_taken;
    count_after = count;
    if (push) count_after = count_after + CNT_W'(1);
    if (pop)  count_after = count_after - CNT_W'(1);
  end

  // Next PC for the PC register: redirect wins, then advance on an accepted fetch
  always_comb begin
    if (!rst_n)            new_pc = RESET_PC;
    else if (branch_taken) new_pc = branch_target;
    else if (push)         new_pc = current_pc + STEP;
    else                   new_pc = current_pc;
  end

  // Request sequencing: start, continue back-to-back, or drain a stale response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      req_addr <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if ((count < FULL) && !branch_taken) begin
            state    <= REQ;
            req_addr <= current_pc;
          end
        end
        REQ: begin
          if (branch_taken) begin
            state <= imem_ready ? IDLE : DROP;
          end else if (imem_ready) begin
            if (count_after < FULL) req_addr <= req_addr + STEP;
            else                    state    <= IDLE;
          end
        end
        DROP: begin
          if (imem_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Fetch buffer occupancy and pointers; a redirect flushes everything at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (branch_taken) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      count <= count_after;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Fetch buffer storage; contents are only meaningful while counted as valid
  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[wr_ptr]    <= req_addr;
      buf_instr[wr_ptr] <= imem_rdata;
    end
  end

  assign imem_req  = (state != IDLE);
  assign imem_addr = req_addr;
  assign if_valid  = (count != '0);
  assign if_pc     = buf_pc[rd_ptr];
  assign if_instr  = buf_instr[rd_ptr];

endmodule
